// File: rtl/fetch_unit.sv
// Multicycle instruction fetch / PC sequencer: FETCH -> EXEC -> (DATA) -> FETCH, with an absorbing HALTED state.
// Optional build macro JR_ALIGN_CHECK_EN: misaligned jr targets halt the core and raise a sticky fault.
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h00000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] instr_in,
  output logic        iREN,
  output logic [31:0] iaddr,
  output logic [31:0] instr,
  input  logic        beq_s,
  input  logic        bne_s,
  input  logic        jump_s,
  input  logic        jr_s,
  input  logic        jal_s,
  input  logic        halt,
  input  logic        dREN_in,
  input  logic        dWEN_in,
  input  logic        zero,
  input  logic [15:0] imm_addr,
  input  logic [25:0] j_addr,
  input  logic [31:0] rs_data,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] pc_plus4,
  output logic        halt_out,
  output logic        fault,
  input  logic        dhit
);

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    DATA,
    HALTED
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pc_target;
  logic [31:0] branch_offset;
  logic [31:0] jr_target;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic        jr_misaligned;

  assign iaddr    = pc;
  assign pc_plus4 = pc + 32'd4;
  assign halt_out = (state == HALTED);

  assign branch_offset = {{14{imm_addr[15]}}, imm_addr, 2'b00};
  assign jr_target     = {rs_data[31:2], 2'b00};
  assign jump_target   = {pc_plus4[31:28], j_addr, 2'b00};
  assign branch_taken  = (beq_s & zero) | (bne_s & ~zero);

`ifdef JR_ALIGN_CHECK_EN
  assign jr_misaligned = jr_s & (rs_data[1:0] != 2'b00);
`else
  // Low target bits are simply dropped when the alignment check is not built in.
  logic jr_low_unused;
  assign jr_low_unused = ^rs_data[1:0];
  assign jr_misaligned = 1'b0;
`endif

  always_comb begin
    pc_target = pc_plus4;
    if (jr_s) begin
      pc_target = jr_target;
    end else if (jump_s | jal_s) begin
      pc_target = jump_target;
    end else if (branch_taken) begin
      pc_target = pc_plus4 + branch_offset;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    iREN       = 1'b0;
    dREN       = 1'b0;
    dWEN       = 1'b0;
    case (state)
      FETCH: begin
        iREN = 1'b1;
        if (ihit) begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        // halt outranks every other decode input, including a pending memory access
        if (halt || jr_misaligned) begin
          state_next = HALTED;
        end else if (dREN_in || dWEN_in) begin
          state_next = DATA;
        end else begin
          pc_next    = pc_target;
          state_next = FETCH;
        end
      end
      DATA: begin
        dREN = dREN_in;
        dWEN = dWEN_in;
        if (dhit) begin
          pc_next    = pc_target;
          state_next = FETCH;
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= FETCH;
      pc    <= PC_INIT;
      instr <= 32'h00000000;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (state == FETCH && ihit) begin
        instr <= instr_in;
      end
    end
  end

`ifdef JR_ALIGN_CHECK_EN
  logic fault_q;

  // Sticky until reset; a simultaneous halt wins and does not flag a fault.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fault_q <= 1'b0;
    end else if (state == EXEC && !halt && jr_misaligned) begin
      fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed corner cases followed by randomized instruction
// streams, compared against a transaction-level model of the PC and instruction register.
module tb_fetch_unit;

  localparam logic [31:0] PC_INIT = 32'h00000000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit;
  logic [31:0] instr_in;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] instr;
  logic        beq_s, bne_s, jump_s, jr_s, jal_s, halt, dREN_in, dWEN_in, zero;
  logic [15:0] imm_addr;
  logic [25:0] j_addr;
  logic [31:0] rs_data;
  logic        dREN, dWEN;
  logic [31:0] pc_plus4;
  logic        halt_out, fault;
  logic        dhit;

  int checks = 0;
  int errors = 0;

  // Fields of the instruction currently being executed
  logic        f_jr, f_jump, f_jal, f_beq, f_bne, f_zero, f_halt, f_dren, f_dwen;
  logic [15:0] f_imm;
  logic [25:0] f_jaddr;
  logic [31:0] f_rs;

  logic [31:0] model_pc;
  logic [31:0] model_instr;
  bit          model_halted;
  bit          model_fault;

  fetch_unit #(.PC_INIT(PC_INIT)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .instr_in(instr_in),
    .iREN(iREN), .iaddr(iaddr), .instr(instr),
    .beq_s(beq_s), .bne_s(bne_s), .jump_s(jump_s), .jr_s(jr_s), .jal_s(jal_s),
    .halt(halt), .dREN_in(dREN_in), .dWEN_in(dWEN_in), .zero(zero),
    .imm_addr(imm_addr), .j_addr(j_addr), .rs_data(rs_data),
    .dREN(dREN), .dWEN(dWEN), .pc_plus4(pc_plus4), .halt_out(halt_out),
    .fault(fault), .dhit(dhit)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drives the decode inputs either from the current fields or with random noise.
  task automatic applyStimulus(input bit use_fields);
    if (use_fields) begin
      jr_s = f_jr; jump_s = f_jump; jal_s = f_jal; beq_s = f_beq; bne_s = f_bne;
      zero = f_zero; halt = f_halt; dREN_in = f_dren; dWEN_in = f_dwen;
      imm_addr = f_imm; j_addr = f_jaddr; rs_data = f_rs;
    end else begin
      jr_s = 1'($urandom); jump_s = 1'($urandom); jal_s = 1'($urandom);
      beq_s = 1'($urandom); bne_s = 1'($urandom); zero = 1'($urandom);
      halt = 1'($urandom); dREN_in = 1'($urandom); dWEN_in = 1'($urandom);
      imm_addr = 16'($urandom); j_addr = 26'($urandom); rs_data = $urandom;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_fields();
    f_jr = 0; f_jump = 0; f_jal = 0; f_beq = 0; f_bne = 0; f_zero = 0;
    f_halt = 0; f_dren = 0; f_dwen = 0; f_imm = '0; f_jaddr = '0; f_rs = '0;
  endtask

  // Architectural next-PC rule, written with plain arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] pc);
    logic [31:0] p4;
    int          off;
    p4 = pc + 32'd4;
    if (f_jr) return f_rs & 32'hFFFF_FFFC;
    if (f_jump || f_jal) return (p4 & 32'hF000_0000) | (32'(f_jaddr) << 2);
    if ((f_beq && f_zero) || (f_bne && !f_zero)) begin
      off = int'($signed(f_imm));
      return p4 + 32'(off * 4);
    end
    return p4;
  endfunction

  task automatic check_reset_state();
    applyStimulus(0);
    ihit = 1'b0; dhit = 1'b1; dREN_in = 1'b1; dWEN_in = 1'b1;
    #1;
    checkOutput("rst_iREN", 32'(iREN), 32'd1);
    checkOutput("rst_iaddr", iaddr, PC_INIT);
    checkOutput("rst_dREN", 32'(dREN), 32'd0);
    checkOutput("rst_dWEN", 32'(dWEN), 32'd0);
    checkOutput("rst_halt_out", 32'(halt_out), 32'd0);
    checkOutput("rst_fault", 32'(fault), 32'd0);
    checkOutput("rst_instr", instr, 32'h0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    applyStimulus(0);
    ihit = 1'($urandom); dhit = 1'($urandom); instr_in = $urandom;
    tick();
    tick();
    RST = 1'b0;
    model_pc = PC_INIT; model_instr = 32'h0; model_halted = 0; model_fault = 0;
    check_reset_state();
  endtask

  task automatic check_halted(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(0);
      ihit = 1'($urandom); dhit = 1'($urandom); instr_in = $urandom;
      #1;
      checkOutput("hlt_iREN", 32'(iREN), 32'd0);
      checkOutput("hlt_halt_out", 32'(halt_out), 32'd1);
      checkOutput("hlt_dREN", 32'(dREN), 32'd0);
      checkOutput("hlt_dWEN", 32'(dWEN), 32'd0);
      checkOutput("hlt_iaddr", iaddr, model_pc);
      checkOutput("hlt_instr", instr, model_instr);
      checkOutput("hlt_fault", 32'(fault), 32'(model_fault));
      tick();
    end
  endtask

  // One whole instruction: fetch (with ihit after fetch_wait cycles), execute, optional data phase.
  task automatic runInstr(input int fetch_wait, input logic [31:0] word, input int mem_wait,
                          input bit rst_in_data);
    logic [31:0] target;
    bit          mis;
    for (int k = 0; k <= fetch_wait; k++) begin
      applyStimulus(0);
      ihit = (k == fetch_wait);
      instr_in = ihit ? word : $urandom;
      dhit = 1'($urandom);
      #1;
      checkOutput("fetch_iREN", 32'(iREN), 32'd1);
      checkOutput("fetch_iaddr", iaddr, model_pc);
      checkOutput("fetch_pc_plus4", pc_plus4, model_pc + 32'd4);
      checkOutput("fetch_dREN", 32'(dREN), 32'd0);
      checkOutput("fetch_dWEN", 32'(dWEN), 32'd0);
      checkOutput("fetch_halt_out", 32'(halt_out), 32'd0);
      checkOutput("fetch_fault", 32'(fault), 32'(model_fault));
      tick();
    end
    model_instr = word;

    applyStimulus(1);
    ihit = 1'($urandom); instr_in = $urandom; dhit = 1'($urandom);
    #1;
    checkOutput("exec_iREN", 32'(iREN), 32'd0);
    checkOutput("exec_instr", instr, model_instr);
    checkOutput("exec_iaddr", iaddr, model_pc);
    checkOutput("exec_dREN", 32'(dREN), 32'd0);
    checkOutput("exec_dWEN", 32'(dWEN), 32'd0);
    target = ref_next(model_pc);
`ifdef JR_ALIGN_CHECK_EN
    mis = f_jr && (f_rs[1:0] != 2'b00);
`else
    mis = 0;
`endif
    tick();

    if (f_halt || mis) begin
      model_halted = 1;
      if (!f_halt) model_fault = 1;
      return;
    end

    if (f_dren || f_dwen) begin
      for (int d = 0; d <= mem_wait; d++) begin
        applyStimulus(1);
        ihit = 1'($urandom); instr_in = $urandom;
        if (rst_in_data) begin
          RST = 1'b1; dhit = 1'b1;
          #1;
          checkOutput("data_dREN_pre_rst", 32'(dREN), 32'(f_dren));
          tick();
          RST = 1'b0;
          model_pc = PC_INIT; model_instr = 32'h0; model_halted = 0; model_fault = 0;
          return;
        end
        dhit = (d == mem_wait);
        #1;
        checkOutput("data_iREN", 32'(iREN), 32'd0);
        checkOutput("data_dREN", 32'(dREN), 32'(f_dren));
        checkOutput("data_dWEN", 32'(dWEN), 32'(f_dwen));
        checkOutput("data_iaddr", iaddr, model_pc);
        tick();
      end
    end
    model_pc = target;
  endtask

  task automatic jump_to(input logic [31:0] addr);
    clear_fields();
    f_jr = 1; f_rs = addr;
    runInstr(0, 32'h03E00008, 0, 0);
  endtask

  initial begin
    RST = 1'b1; ihit = 0; dhit = 0; instr_in = '0;
    clear_fields();
    applyStimulus(1);
    do_reset();

    // Straight-line ADDI stream with ihit always high
    clear_fields();
    for (int i = 0; i < 3; i++) runInstr(0, 32'h20010001 + 32'(i), 0, 0);

    // Backward branch onto itself, then the not-taken case
    jump_to(32'h40);
    clear_fields(); f_beq = 1; f_zero = 1; f_imm = 16'hFFFF;
    runInstr(0, 32'h1000FFFF, 0, 0);
    f_zero = 0;
    runInstr(1, 32'h1000FFFF, 0, 0);

    // Load with dhit held off for three cycles
    clear_fields(); f_dren = 1;
    runInstr(0, 32'h8C220000, 3, 0);

    // PC wrap and jal target formation
    jump_to(32'hFFFF_FFFC);
    clear_fields();
    runInstr(0, 32'h20010001, 0, 0);
    jump_to(32'h0040_0000);
    clear_fields(); f_jal = 1; f_jaddr = 26'h10;
    runInstr(0, 32'h0C000010, 0, 0);

    // Misaligned jr target
    clear_fields(); f_jr = 1; f_rs = 32'h102;
    runInstr(0, 32'h00400008, 0, 0);
    if (model_halted) begin
      check_halted(3);
      do_reset();
    end
    clear_fields();
    runInstr(0, 32'h0, 0, 0);

    // halt together with jr: halt wins, later ihit ignored, reset recovers
    clear_fields(); f_halt = 1; f_jr = 1; f_rs = 32'h103;
    runInstr(0, 32'hFFFFFFFF, 0, 0);
    check_halted(6);
    do_reset();

    // Reset in the middle of a store
    clear_fields(); f_dwen = 1;
    runInstr(1, 32'hAC220000, 5, 1);
    check_reset_state();

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      f_jr    = ($urandom_range(0, 5) == 0);
      f_jump  = ($urandom_range(0, 7) == 0);
      f_jal   = ($urandom_range(0, 7) == 0);
      f_beq   = ($urandom_range(0, 3) == 0);
      f_bne   = ($urandom_range(0, 3) == 0);
      f_zero  = 1'($urandom);
      f_halt  = ($urandom_range(0, 15) == 0);
      f_dren  = ($urandom_range(0, 3) == 0);
      f_dwen  = ($urandom_range(0, 4) == 0);
      f_imm   = 16'($urandom);
      f_jaddr = 26'($urandom);
      f_rs    = $urandom;
      runInstr(int'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 3)), 0);
      if (model_halted) begin
        check_halted(int'($urandom_range(1, 4)));
        do_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter PC_INIT, default 32'h00000000, giving the program counter value after reset.
REQ-002 SHALL provide port CLK  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL provide port RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide ports ihit input 1 (icache hit) and instr_in input 32 (icache load data).
REQ-005 SHALL provide ports iREN output 1 (instruction read request) and iaddr output 32 (fetch address, always equal to the PC register).
REQ-006 SHALL provide port instr output 32, the latched instruction word driven to control-unit decode.
REQ-007 SHALL provide decode-feedback inputs beq_s, bne_s, jump_s, jr_s, jal_s, halt, dREN_in and dWEN_in, each 1 bit.
REQ-008 SHALL provide inputs zero (1, ALU zero flag), imm_addr (16), j_addr (26) and rs_data (32, jr target).
REQ-009 SHALL provide outputs dREN (1), dWEN (1), pc_plus4 (32, link value for jal), halt_out (1) and fault (1).
REQ-010 SHALL provide input dhit (1, dcache hit).

Function
REQ-011 SHALL implement states FETCH, EXEC, DATA and HALTED.
REQ-012 In FETCH: iREN=1; on ihit, capture instr_in into instr and go to EXEC; without ihit, remain in FETCH with PC held.
REQ-013 In EXEC with halt=1: go to HALTED with PC unchanged; halt takes priority over all other inputs.
REQ-014 In EXEC with dREN_in or dWEN_in set: go to DATA with PC unchanged.
REQ-015 In EXEC otherwise: load the next PC and go to FETCH.
REQ-016 In DATA: dREN=dREN_in and dWEN=dWEN_in; on dhit, load the next PC and go to FETCH; otherwise hold state and PC.
REQ-017 In all states other than DATA: dREN=0 and dWEN=0.
REQ-018 Next-PC priority SHALL be jr_s, then jump_s|jal_s, then taken branch, then pc_plus4.
REQ-019 Next-PC target for jr_s SHALL be rs_data.
REQ-020 Next-PC target for jump_s|jal_s SHALL be {pc_plus4[31:28], j_addr, 2'b00}.
REQ-021 A branch is taken when (beq_s & zero) | (bne_s & ~zero); the taken target SHALL be pc_plus4 + (sign-extended imm_addr << 2).
REQ-022 All PC arithmetic SHALL be 32-bit modulo 2^32: PC 32'hFFFFFFFC advances to 32'h00000000.
REQ-023 pc_plus4 SHALL equal PC+4 combinationally in every state.
REQ-024 HALTED SHALL be absorbing until reset: iREN=0, dREN=0, dWEN=0, halt_out=1, and PC and instr held.
REQ-025 ihit outside FETCH and dhit outside DATA SHALL be ignored.
REQ-026 Minimum latency: 2 cycles per non-memory instruction (ihit in the first FETCH cycle); memory instructions add at least 1 DATA cycle.

Reset
REQ-027 When RST=1 at a clock edge: state=FETCH, PC=PC_INIT, instr=32'h00000000, halt_out=0 and fault=0, regardless of ihit, dhit or current state.
REQ-028 In the first cycle after reset: iREN=1, iaddr=PC_INIT, dREN=0 and dWEN=0.
REQ-029 Reset asserted mid-DATA or in HALTED SHALL drop dREN/dWEN at the next edge and discard any pending PC update.

Configuration
REQ-030 With macro JR_ALIGN_CHECK_EN defined: in EXEC with jr_s=1 and rs_data[1:0]!=0, go to HALTED, set fault=1 (sticky until reset) and set halt_out=1; PC unchanged.
REQ-031 Without JR_ALIGN_CHECK_EN: the jr target SHALL be {rs_data[31:2], 2'b00}, and fault SHALL be constant 0.

Verification
REQ-032 Reset, then ihit=1 every cycle with ADDI words -> iaddr sequence 0,4,8 at 2-cycle spacing; dREN=dWEN=0.
REQ-033 EXEC at PC=0x40 with beq_s=1, zero=1, imm_addr=16'hFFFF -> next iaddr 0x40; repeat with zero=0 -> next iaddr 0x44.
REQ-034 EXEC with LW (dREN_in=1) and dhit held low 3 cycles -> dREN=1 for 4 cycles and PC stable; after dhit -> iaddr=PC+4.
REQ-035 EXEC at PC=0xFFFFFFFC with no control-flow input -> iaddr wraps to 0x00000000; jal_s with j_addr=26'h10 at PC=0x00400000 -> iaddr 0x00000040.
REQ-036 EXEC with halt=1 and jr_s=1 simultaneously -> HALTED, halt_out=1, iREN=0; later ihit pulses ignored; RST=1 -> iaddr=PC_INIT and halt_out=0.
REQ-037 JR_ALIGN_CHECK_EN defined, jr_s=1 with rs_data=0x102 -> fault=1 and HALTED; undefined -> iaddr=0x100 and fault=0.
